// File: rtl/axi4_stream_pkt_len_meter_if.sv
// AXI4-Stream interface bundle used by axi4_stream_pkt_len_meter.
//   master modport: drives tvalid/tdata/tkeep/tstrb/tid/tdest/tuser/tlast, samples tready
//   slave  modport: samples the payload signals, drives tready
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tkeep;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic [ID_WIDTH-1:0]       tid;
    logic [DEST_WIDTH-1:0]     tdest;
    logic [USER_WIDTH-1:0]     tuser;
    logic                      tlast;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tid, tdest, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tid, tdest, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_len_meter.sv
// Packet length meter: forwards an AXI4-Stream through a registered two-entry
// skid stage and pushes one {oversize, byte_length} record per packet into a
// small FIFO exposed as a valid/ready sideband.
//   clk_i, rst_i       clock, synchronous active-high reset
//   max_pkt_size_i     oversize threshold, latched on each packet's first beat
//   pkt_i / pkt_o      input / output stream (identical widths)
//   len_data_o         head record byte length (saturating)
//   len_oversize_o     head record oversize flag
//   len_valid_o        head record present
//   len_ready_i        head record consumed
//   oversize_cnt_o     saturating count of oversize packets since reset
module axi4_stream_pkt_len_meter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 1,
    parameter int USER_WIDTH     = 1,
    parameter int MAX_PKT_SIZE_B = 2048,
    parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B),
    parameter int LEN_FIFO_DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [PKT_SIZE_WIDTH:0] max_pkt_size_i,
    axi4_stream_if.slave            pkt_i,
    axi4_stream_if.master           pkt_o,
    output logic [PKT_SIZE_WIDTH:0] len_data_o,
    output logic                    len_oversize_o,
    output logic                    len_valid_o,
    input  logic                    len_ready_i,
    output logic [15:0]             oversize_cnt_o
);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int LEN_W  = PKT_SIZE_WIDTH + 1;
    localparam int CNT_W  = $clog2(KEEP_W) + 1;
    localparam int BEAT_W = DATA_WIDTH + 2 * KEEP_W + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
    localparam int AW     = $clog2(LEN_FIFO_DEPTH);
    localparam int PTR_W  = AW + 1;

    // ---------------------------------------------------------------- skid stage
    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_q, main_d;
    logic [BEAT_W-1:0] skid_q, skid_d;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              rdy_q, rdy_d;
    logic              full_q, empty_q;
    logic              in_ready;
    logic              in_fire;
    logic              out_free;

    assign in_beat = {pkt_i.tdata, pkt_i.tkeep, pkt_i.tstrb, pkt_i.tid,
                      pkt_i.tdest, pkt_i.tuser, pkt_i.tlast};

    // A tlast beat would push a record, so it is held off while the FIFO is full.
    assign in_ready    = rdy_q && !(full_q && pkt_i.tlast);
    assign pkt_i.tready = in_ready;
    assign in_fire     = pkt_i.tvalid && in_ready;

    assign pkt_o.tvalid = main_valid_q;
    assign {pkt_o.tdata, pkt_o.tkeep, pkt_o.tstrb, pkt_o.tid,
            pkt_o.tdest, pkt_o.tuser, pkt_o.tlast} = main_q;

    assign out_free = !main_valid_q || pkt_o.tready;

    // rdy_q mirrors "skid empty next cycle", so an accepted beat always has
    // either the main slot or the skid slot free to land in.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (out_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d = in_beat;
                end
            end
        end else if (in_fire) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        rdy_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
        end
    end

    // ---------------------------------------------------------------- length meter
    logic [CNT_W-1:0] beat_bytes;
    logic [LEN_W-1:0] acc_q, acc_base, acc_new;
    logic [LEN_W:0]   acc_sum;
    logic [LEN_W-1:0] max_q, eff_max;
    logic             first_q;
    logic             oversize_new;
    logic             push;
    logic [15:0]      ov_cnt_q;

    always_comb begin
        beat_bytes = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            beat_bytes = beat_bytes + CNT_W'(pkt_i.tkeep[i] | pkt_i.tstrb[i]);
        end
    end

    assign acc_base = first_q ? '0 : acc_q;
    assign acc_sum  = {1'b0, acc_base} + (LEN_W + 1)'(beat_bytes);
    assign acc_new  = acc_sum[LEN_W] ? '1 : acc_sum[LEN_W-1:0];
    // On a single-beat packet the threshold has not been latched yet.
    assign eff_max      = first_q ? max_pkt_size_i : max_q;
    assign oversize_new = acc_new > eff_max;
    assign push         = in_fire && pkt_i.tlast;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            max_q    <= '0;
            first_q  <= 1'b1;
            ov_cnt_q <= '0;
        end else if (in_fire) begin
            acc_q   <= acc_new;
            first_q <= pkt_i.tlast;
            if (first_q) begin
                max_q <= max_pkt_size_i;
            end
            if (push && oversize_new && (ov_cnt_q != 16'hFFFF)) begin
                ov_cnt_q <= ov_cnt_q + 16'd1;
            end
        end
    end

    assign oversize_cnt_o = ov_cnt_q;

    // ---------------------------------------------------------------- length FIFO
    logic [LEN_W:0]   mem [LEN_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic             full_d, empty_d;
    logic             pop;
    logic [LEN_W:0]   head;

    assign pop     = !empty_q && len_ready_i;
    assign wr_d    = wr_q + PTR_W'(push);
    assign rd_d    = rd_q + PTR_W'(pop);
    assign empty_d = (wr_d == rd_d);
    assign full_d  = (wr_d[AW-1:0] == rd_d[AW-1:0]) && (wr_d[AW] != rd_d[AW]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem[wr_q[AW-1:0]] <= {oversize_new, acc_new};
        end
    end

    assign head           = mem[rd_q[AW-1:0]];
    assign len_valid_o    = !empty_q;
    assign len_data_o     = empty_q ? '0 : head[LEN_W-1:0];
    assign len_oversize_o = empty_q ? 1'b0 : head[LEN_W];
endmodule

// File: tb/tb_axi4_stream_pkt_len_meter.sv
`timescale 1ns/1ps
module tb_axi4_stream_pkt_len_meter;
    localparam int DW = 32;
    localparam int LW = 12;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [3:0]  strb;
        logic        id;
        logic        dest;
        logic        user;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic          ov;
        logic [LW-1:0] len;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [LW-1:0] max_size = '0;
    logic          len_ready;
    logic [LW-1:0] len_data;
    logic          len_ov;
    logic          len_valid;
    logic [15:0]   ov_cnt;

    axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) in_if ();
    axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) out_if ();

    axi4_stream_pkt_len_meter #(
        .DATA_WIDTH(DW), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1),
        .MAX_PKT_SIZE_B(2048), .LEN_FIFO_DEPTH(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .max_pkt_size_i(max_size),
        .pkt_i(in_if), .pkt_o(out_if),
        .len_data_o(len_data), .len_oversize_o(len_ov), .len_valid_o(len_valid),
        .len_ready_i(len_ready), .oversize_cnt_o(ov_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tmo   = 0;

    // Ready drivers: random or fixed, updated 2 ns after each rising edge.
    bit   rand_mode = 1'b0;
    logic fix_out_ready = 1'b1;
    logic fix_len_ready = 1'b1;
    initial begin
        out_if.tready = 1'b1;
        len_ready     = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rand_mode) begin
                out_if.tready = 1'($urandom % 2);
                len_ready     = 1'($urandom % 2);
            end else begin
                out_if.tready = fix_out_ready;
                len_ready     = fix_len_ready;
            end
        end
    end

    // Monitor: samples handshakes on the falling edge.
    int    cyc = 0;
    beat_t mon_out[$];
    int    mon_out_cyc[$];
    int    mon_in_cyc[$];
    rec_t  mon_rec[$];
    int    mon_rec_cyc[$];

    function automatic beat_t out_beat();
        beat_t b;
        b.data = out_if.tdata; b.keep = out_if.tkeep; b.strb = out_if.tstrb;
        b.id = out_if.tid; b.dest = out_if.tdest; b.user = out_if.tuser; b.last = out_if.tlast;
        return b;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (in_if.tvalid && in_if.tready) mon_in_cyc.push_back(cyc);
                if (out_if.tvalid && out_if.tready) begin
                    mon_out.push_back(out_beat());
                    mon_out_cyc.push_back(cyc);
                end
                if (len_valid && len_ready) begin
                    mon_rec.push_back({len_ov, len_data});
                    mon_rec_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_out.delete(); mon_out_cyc.delete(); mon_in_cyc.delete();
        mon_rec.delete(); mon_rec_cyc.delete();
    endtask

    task automatic set_in(input beat_t b);
        in_if.tdata = b.data; in_if.tkeep = b.keep; in_if.tstrb = b.strb;
        in_if.tid = b.id; in_if.tdest = b.dest; in_if.tuser = b.user; in_if.tlast = b.last;
    endtask

    task automatic drive_beat(input beat_t b);
        bit ok;
        ok = 1'b0;
        set_in(b);
        in_if.tvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_if.tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo++;
        tick();
    endtask

    function automatic beat_t mk_beat(input logic [3:0] keep, input logic last);
        beat_t b;
        b.data = $urandom; b.keep = keep; b.strb = keep;
        b.id = 1'($urandom); b.dest = 1'($urandom); b.user = 1'($urandom); b.last = last;
        return b;
    endfunction

    task automatic drain(input int n_beats, input int n_recs);
        for (int i = 0; i < 3000; i++) begin
            if (mon_out.size() >= n_beats && mon_rec.size() >= n_recs) break;
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        bit seen;
        in_if.tvalid = 1'b0;
        set_in('0);
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++; if (out_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_out_tvalid got=%b want=0", out_if.tvalid); end
        total++; if (len_valid !== 1'b0) begin bad++; $display("FAIL reset_len_valid got=%b want=0", len_valid); end
        total++; if (len_data !== '0 || len_ov !== 1'b0) begin bad++; $display("FAIL reset_len_data got=%0d/%b want=0/0", len_data, len_ov); end
        total++; if (ov_cnt !== 16'd0) begin bad++; $display("FAIL reset_ov_cnt got=%0d want=0", ov_cnt); end
        total++; if (in_if.tready !== 1'b0) begin bad++; $display("FAIL reset_in_tready got=%b want=0", in_if.tready); end
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (in_if.tready === 1'b1) seen = 1'b1;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL post_reset_tready got=%b want=1", seen); end
        tick();
    endtask

    task automatic test_basic();
        beat_t exp[$];
        clear_mon(); tmo = 0;
        max_size = 12'd16;
        for (int i = 0; i < 4; i++) exp.push_back(mk_beat((i == 3) ? 4'b0011 : 4'b1111, i == 3));
        foreach (exp[i]) drive_beat(exp[i]);
        in_if.tvalid = 1'b0;
        drain(4, 1);
        total++; if (tmo !== 0) begin bad++; $display("FAIL basic_accept_timeout got=%0d want=0", tmo); end
        total++;
        if (mon_out.size() !== 4 || mon_in_cyc.size() !== 4) begin
            bad++; $display("FAIL basic_beat_count got=%0d/%0d want=4/4", mon_out.size(), mon_in_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (mon_out[i] !== exp[i]) begin bad++; $display("FAIL basic_beat%0d got=%h want=%h", i, mon_out[i], exp[i]); end
                total++; if (mon_out_cyc[i] !== mon_in_cyc[i] + 1) begin bad++; $display("FAIL basic_latency%0d got=%0d want=%0d", i, mon_out_cyc[i], mon_in_cyc[i] + 1); end
            end
        end
        total++;
        if (mon_rec.size() !== 1) begin
            bad++; $display("FAIL basic_rec_count got=%0d want=1", mon_rec.size());
        end else begin
            total++; if (mon_rec[0] !== {1'b0, 12'd14}) begin bad++; $display("FAIL basic_rec got=%0d/%b want=14/0", mon_rec[0].len, mon_rec[0].ov); end
            total++; if (mon_in_cyc.size() == 4 && mon_rec_cyc[0] !== mon_in_cyc[3] + 1) begin bad++; $display("FAIL basic_rec_timing got=%0d want=%0d", mon_rec_cyc[0], mon_in_cyc[3] + 1); end
        end
    endtask

    task automatic test_oversize();
        beat_t exp[$];
        clear_mon(); tmo = 0;
        max_size = 12'd8;
        for (int i = 0; i < 3; i++) exp.push_back(mk_beat(4'b1111, i == 2));
        foreach (exp[i]) drive_beat(exp[i]);
        in_if.tvalid = 1'b0;
        drain(3, 1);
        total++; if (mon_rec.size() !== 1 || mon_rec[0] !== {1'b1, 12'd12}) begin bad++; $display("FAIL ovs_rec got_n=%0d want=12/1", mon_rec.size()); end
        total++; if (ov_cnt !== 16'd1) begin bad++; $display("FAIL ovs_cnt got=%0d want=1", ov_cnt); end
        total++; if (mon_out.size() !== 3 || mon_out[0] !== exp[0] || mon_out[2] !== exp[2]) begin bad++; $display("FAIL ovs_forward got_n=%0d want=3 beats unchanged", mon_out.size()); end
    endtask

    task automatic test_fifo_full();
        beat_t b;
        clear_mon(); tmo = 0;
        max_size = 12'd8;
        fix_len_ready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) drive_beat(mk_beat(4'b1111, 1'b1));
        b = mk_beat(4'b1111, 1'b1);
        set_in(b);
        in_if.tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (in_if.tready !== 1'b0) begin bad++; $display("FAIL full_stall%0d got=%b want=0", i, in_if.tready); end
        end
        total++; if (len_valid !== 1'b1 || len_data !== 12'd4) begin bad++; $display("FAIL full_head got=%b/%0d want=1/4", len_valid, len_data); end
        @(posedge clk);
        #1 fix_len_ready = 1'b1;
        @(negedge clk);
        total++; if (in_if.tready !== 1'b0) begin bad++; $display("FAIL full_pop_same_cycle got=%b want=0", in_if.tready); end
        @(posedge clk);
        #1 fix_len_ready = 1'b0;
        @(negedge clk);
        total++; if (in_if.tready !== 1'b1) begin bad++; $display("FAIL full_unblock got=%b want=1", in_if.tready); end
        tick();
        in_if.tvalid = 1'b0;
        fix_len_ready = 1'b1;
        drain(9, 9);
        total++; if (mon_in_cyc.size() !== 9) begin bad++; $display("FAIL full_in_count got=%0d want=9", mon_in_cyc.size()); end
        total++;
        if (mon_rec.size() !== 9) begin
            bad++; $display("FAIL full_rec_count got=%0d want=9", mon_rec.size());
        end else begin
            foreach (mon_rec[i]) begin
                total++; if (mon_rec[i] !== {1'b0, 12'd4}) begin bad++; $display("FAIL full_rec%0d got=%0d/%b want=4/0", i, mon_rec[i].len, mon_rec[i].ov); end
            end
        end
    endtask

    task automatic test_random();
        beat_t exp[$];
        rec_t  exp_rec[$];
        beat_t pkt[$];
        int    len, m, n_ov, first_bad;
        rst = 1'b1; in_if.tvalid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        clear_mon(); tmo = 0; n_ov = 0;
        rand_mode = 1'b1;
        for (int p = 0; p < 200; p++) begin
            do begin
                pkt.delete(); len = 0;
                for (int k = 0, nb = $urandom_range(1, 16); k < nb; k++) begin
                    beat_t b;
                    b = mk_beat(4'($urandom), k == nb - 1);
                    b.strb = 4'($urandom);
                    len += $countones(b.keep | b.strb);
                    pkt.push_back(b);
                end
            end while (len == 0);
            m = $urandom_range(1, 64);
            max_size = LW'(m);
            exp_rec.push_back({(len > m), LW'(len)});
            if (len > m) n_ov++;
            foreach (pkt[k]) begin
                exp.push_back(pkt[k]);
                drive_beat(pkt[k]);
            end
        end
        in_if.tvalid = 1'b0;
        rand_mode = 1'b0;
        drain(exp.size(), 200);
        total++; if (tmo !== 0) begin bad++; $display("FAIL rand_accept_timeout got=%0d want=0", tmo); end
        total++; if (mon_out.size() !== exp.size()) begin bad++; $display("FAIL rand_beat_count got=%0d want=%0d", mon_out.size(), exp.size()); end
        first_bad = -1;
        foreach (exp[i]) if (first_bad < 0 && (i >= mon_out.size() || mon_out[i] !== exp[i])) first_bad = i;
        total++; if (first_bad !== -1) begin bad++; $display("FAIL rand_stream first differing beat got=%0d want=-1", first_bad); end
        total++; if (mon_rec.size() !== 200) begin bad++; $display("FAIL rand_rec_count got=%0d want=200", mon_rec.size()); end
        first_bad = -1;
        foreach (exp_rec[i]) if (first_bad < 0 && (i >= mon_rec.size() || mon_rec[i] !== exp_rec[i])) first_bad = i;
        total++; if (first_bad !== -1) begin bad++; $display("FAIL rand_records first differing record got=%0d want=-1", first_bad); end
        total++; if (ov_cnt !== 16'(n_ov)) begin bad++; $display("FAIL rand_ov_cnt got=%0d want=%0d", ov_cnt, n_ov); end
    endtask

    task automatic test_mid_reset();
        beat_t exp[$];
        clear_mon(); tmo = 0;
        max_size = 12'd64;
        drive_beat(mk_beat(4'b1111, 1'b0));
        set_in(mk_beat(4'b1111, 1'b0));
        in_if.tvalid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        in_if.tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (out_if.tvalid !== 1'b0) begin bad++; $display("FAIL midrst_out_tvalid got=%b want=0", out_if.tvalid); end
        total++; if (len_valid !== 1'b0) begin bad++; $display("FAIL midrst_len_valid got=%b want=0", len_valid); end
        total++; if (ov_cnt !== 16'd0) begin bad++; $display("FAIL midrst_ov_cnt got=%0d want=0", ov_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 2; i++) exp.push_back(mk_beat(4'b1111, i == 1));
        foreach (exp[i]) drive_beat(exp[i]);
        in_if.tvalid = 1'b0;
        drain(2, 1);
        total++; if (mon_rec.size() !== 1 || mon_rec[0] !== {1'b0, 12'd8}) begin bad++; $display("FAIL midrst_rec got_n=%0d want=8/0", mon_rec.size()); end
        total++; if (mon_out.size() !== 2 || mon_out[0] !== exp[0] || mon_out[1] !== exp[1]) begin bad++; $display("FAIL midrst_stream got_n=%0d want=2", mon_out.size()); end
    endtask

    task automatic test_zero_keep();
        beat_t exp[$];
        clear_mon(); tmo = 0;
        max_size = 12'd8;
        exp.push_back(mk_beat(4'b1111, 1'b0));
        exp.push_back(mk_beat(4'b0000, 1'b0));
        exp.push_back(mk_beat(4'b1111, 1'b1));
        foreach (exp[i]) drive_beat(exp[i]);
        in_if.tvalid = 1'b0;
        drain(3, 1);
        total++; if (mon_rec.size() !== 1 || mon_rec[0] !== {1'b0, 12'd8}) begin bad++; $display("FAIL zero_keep_rec got_n=%0d want=8/0", mon_rec.size()); end
        total++; if (mon_out.size() !== 3 || mon_out[1] !== exp[1]) begin bad++; $display("FAIL zero_keep_forward got_n=%0d want=3", mon_out.size()); end
    endtask

    initial begin
        in_if.tvalid = 1'b0;
        set_in('0);
        test_reset();
        test_basic();
        test_oversize();
        test_fifo_full();
        test_random();
        test_mid_reset();
        test_zero_keep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
